// File: rtl/hazard_detect_unit.sv
// Hazard detection: tracks EX/MEM shadow entries, memory port busy time and
// in-flight branches, and flags hazards to the downstream resolution FSM.
module hazard_detect_unit #(
   parameter int unsigned BR_LAT  = 2,
   parameter int unsigned MEM_LAT = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       id_valid,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic       id_uses_rs1,
   input  logic       id_uses_rs2,
   input  logic [4:0] id_rd,
   input  logic       id_wen,
   input  logic       id_is_load,
   input  logic       id_is_mem,
   input  logic       id_is_branch,
   input  logic       id_br_pred,
   input  logic       ex_br_taken,
   input  logic       pc_freeze,
   input  logic       do_flush,
   output logic       data,
   output logic       fwrd,
   output logic       str,
   output logic       ctrl,
   output logic       branch,
   output logic       crct
);

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       wen;
      logic       is_load;
      logic       is_mem;
   } shadow_t;

   localparam logic [2:0] BR_LOAD  = 3'(BR_LAT);
   localparam logic [2:0] MEM_LOAD = 3'(MEM_LAT);

   shadow_t    ex_q;
   shadow_t    mem_q;
   logic [2:0] busy_q;
   logic       br_pend_q;
   logic       br_pred_q;
   logic [2:0] br_cnt_q;

   logic hit_ex1, hit_ex2;
   logic hit_mem1, hit_mem2;
   logic any_hit, load_hit;
   logic br_capture, br_resolve;

   function automatic logic src_hit(
      input shadow_t    e,
      input logic       used,
      input logic [4:0] rs
   );
      return used & e.valid & e.wen
         & (e.rd == rs) & (rs != 5'd0);
   endfunction

   always_comb begin
      hit_ex1  = src_hit(ex_q,  id_uses_rs1, id_rs1);
      hit_ex2  = src_hit(ex_q,  id_uses_rs2, id_rs2);
      hit_mem1 = src_hit(mem_q, id_uses_rs1, id_rs1);
      hit_mem2 = src_hit(mem_q, id_uses_rs2, id_rs2);
      any_hit  = hit_ex1 | hit_ex2 | hit_mem1 | hit_mem2;
      // load data is not yet available while the load sits in EX
      load_hit = (hit_ex1 | hit_ex2) & ex_q.is_load;
   end

   always_comb begin
      br_capture = id_valid & id_is_branch
         & ~pc_freeze & ~do_flush;
      br_resolve = br_pend_q & (br_cnt_q == 3'd1);
   end

   always_comb begin
      data   = id_valid & any_hit;
      fwrd   = data & ~load_hit;
      str    = id_valid & id_is_mem & (busy_q != 3'd0);
      ctrl   = br_pend_q | (id_valid & id_is_branch);
      branch = br_resolve;
      crct   = br_resolve & (ex_br_taken == br_pred_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q  <= '0;
         mem_q <= '0;
      end else begin
         mem_q <= ex_q;
         if (do_flush) begin
            ex_q.valid <= 1'b0;
         end else begin
            ex_q.valid   <= id_valid & ~pc_freeze;
            ex_q.rd      <= id_rd;
            ex_q.wen     <= id_wen;
            ex_q.is_load <= id_is_load;
            ex_q.is_mem  <= id_is_mem;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= 3'd0;
      end else if (ex_q.valid & ex_q.is_mem) begin
         busy_q <= MEM_LOAD;
      end else if (busy_q != 3'd0) begin
         busy_q <= busy_q - 3'd1;
      end
   end

   // a capture in the resolution cycle simply re-arms the tracker
   always_ff @(posedge clk) begin
      if (rst) begin
         br_pend_q <= 1'b0;
         br_pred_q <= 1'b0;
         br_cnt_q  <= 3'd0;
      end else if (br_capture) begin
         br_pend_q <= 1'b1;
         br_pred_q <= id_br_pred;
         br_cnt_q  <= BR_LOAD;
      end else if (br_pend_q) begin
         br_cnt_q <= br_cnt_q - 3'd1;
         if (br_resolve)
            br_pend_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_hazard_detect_unit.sv
// Scoreboard bench for hazard_detect_unit: directed scenarios with
// hand-derived expectations, then random traffic against a reference model.
module tb_hazard_detect_unit;

   logic       clk;
   logic       rst;
   logic       id_valid;
   logic [4:0] id_rs1, id_rs2, id_rd;
   logic       id_uses_rs1, id_uses_rs2;
   logic       id_wen, id_is_load, id_is_mem;
   logic       id_is_branch, id_br_pred;
   logic       ex_br_taken, pc_freeze, do_flush;
   logic       data, fwrd, str, ctrl, branch, crct;

   hazard_detect_unit #(.BR_LAT(2), .MEM_LAT(3)) dut (
      .clk(clk), .rst(rst),
      .id_valid(id_valid),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1),
      .id_uses_rs2(id_uses_rs2),
      .id_rd(id_rd), .id_wen(id_wen),
      .id_is_load(id_is_load),
      .id_is_mem(id_is_mem),
      .id_is_branch(id_is_branch),
      .id_br_pred(id_br_pred),
      .ex_br_taken(ex_br_taken),
      .pc_freeze(pc_freeze),
      .do_flush(do_flush),
      .data(data), .fwrd(fwrd), .str(str),
      .ctrl(ctrl), .branch(branch), .crct(crct)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   typedef struct {
      string      tag;
      logic [5:0] exp;
   } sb_t;
   sb_t sb_q[$];

   task automatic chk(input string tag,
                      input logic [5:0] got,
                      input logic [5:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%b exp=%b", tag, got, exp);
      end
   endtask

   // reference model state
   logic       m_exv, m_exw, m_exl, m_exm;
   logic [4:0] m_exrd;
   logic       m_mv, m_mw, m_ml, m_mm;
   logic [4:0] m_mrd;
   int         m_busy;
   logic       m_pend, m_pred;
   int         m_bcnt;

   always @(posedge clk) begin
      if (rst) begin
         m_exv <= 0; m_exw <= 0; m_exl <= 0;
         m_exm <= 0; m_exrd <= 0;
         m_mv <= 0; m_mw <= 0; m_ml <= 0;
         m_mm <= 0; m_mrd <= 0;
         m_busy <= 0; m_pend <= 0;
         m_pred <= 0; m_bcnt <= 0;
      end else begin
         m_mv <= m_exv; m_mw <= m_exw;
         m_ml <= m_exl; m_mm <= m_exm;
         m_mrd <= m_exrd;
         m_exv <= id_valid && !pc_freeze && !do_flush;
         if (!do_flush) begin
            m_exw <= id_wen; m_exl <= id_is_load;
            m_exm <= id_is_mem; m_exrd <= id_rd;
         end
         if (m_exv && m_exm) m_busy <= 3;
         else if (m_busy > 0) m_busy <= m_busy - 1;
         if (id_valid && id_is_branch
             && !pc_freeze && !do_flush) begin
            m_pend <= 1; m_pred <= id_br_pred;
            m_bcnt <= 2;
         end else if (m_pend) begin
            m_bcnt <= m_bcnt - 1;
            if (m_bcnt == 1) m_pend <= 0;
         end
      end
   end

   function automatic logic mhit(input logic v, w,
                                 input logic [4:0] rd,
                                 input logic u,
                                 input logic [4:0] rs);
      return u && v && w && rd == rs && rs != 0;
   endfunction

   function automatic logic [5:0] model_out();
      logic e, m, d, f, s, c, b, k;
      e = mhit(m_exv, m_exw, m_exrd, id_uses_rs1, id_rs1)
        || mhit(m_exv, m_exw, m_exrd, id_uses_rs2, id_rs2);
      m = mhit(m_mv, m_mw, m_mrd, id_uses_rs1, id_rs1)
        || mhit(m_mv, m_mw, m_mrd, id_uses_rs2, id_rs2);
      d = id_valid && (e || m);
      f = d && !(e && m_exl);
      s = id_valid && id_is_mem && m_busy != 0;
      b = m_pend && m_bcnt == 1;
      c = m_pend || (id_valid && id_is_branch);
      k = b && (ex_br_taken == m_pred);
      return {d, f, s, c, b, k};
   endfunction

   task automatic clr();
      id_valid = 0; id_rs1 = 0; id_rs2 = 0;
      id_uses_rs1 = 0; id_uses_rs2 = 0;
      id_rd = 0; id_wen = 0; id_is_load = 0;
      id_is_mem = 0; id_is_branch = 0;
      id_br_pred = 0; ex_br_taken = 0;
      pc_freeze = 0; do_flush = 0;
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
      rst = 0;
      clr();
   endtask

   task automatic dec(input logic [4:0] rs1, input logic u1,
                      input logic [4:0] rs2, input logic u2,
                      input logic [4:0] rd, input logic wen,
                      input logic ld, input logic mem,
                      input logic br, input logic pr);
      id_valid = 1;
      id_rs1 = rs1; id_uses_rs1 = u1;
      id_rs2 = rs2; id_uses_rs2 = u2;
      id_rd = rd; id_wen = wen;
      id_is_load = ld; id_is_mem = mem;
      id_is_branch = br; id_br_pred = pr;
   endtask

   task automatic push(input string tag, input logic [5:0] e);
      sb_t x;
      x.tag = tag;
      x.exp = e;
      sb_q.push_back(x);
   endtask

   task automatic idle_n(input int n);
      for (int i = 0; i < n; i++) begin
         nxt();
         push("idle", 6'b000000);
      end
   endtask

   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         sb_t x;
         x = sb_q.pop_front();
         chk(x.tag, {data, fwrd, str, ctrl, branch, crct}, x.exp);
      end
   end

   initial begin
      clr();
      rst = 1;
      repeat (2) @(posedge clk);
      nxt(); push("reset", 6'b000000);

      // ALU writer then dependent reader
      nxt(); dec(0,0, 0,0, 3,1, 0,0, 0,0); push("add_w", 6'b000000);
      nxt(); dec(3,1, 0,0, 4,0, 0,0, 0,0); push("add_fw", 6'b110000);
      nxt(); push("add_idle", 6'b000000);
      // x0 never hazards
      nxt(); dec(0,0, 0,0, 0,1, 0,0, 0,0); push("x0_w", 6'b000000);
      nxt(); dec(0,1, 0,0, 6,0, 0,0, 0,0); push("x0_rd", 6'b000000);
      idle_n(2);

      // load-use: stall once, then forward from MEM
      nxt(); dec(0,0, 0,0, 5,1, 1,1, 0,0); push("ld_w", 6'b000000);
      nxt(); dec(0,0, 5,1, 7,1, 0,0, 0,0); pc_freeze = 1;
      push("ld_use", 6'b100000);
      nxt(); dec(0,0, 5,1, 7,1, 0,0, 0,0); push("ld_fw", 6'b110000);
      idle_n(4);

      // memory port busy window
      nxt(); dec(0,0, 0,0, 0,0, 0,1, 0,0); push("st_t-1", 6'b000000);
      for (int i = 0; i < 5; i++) begin
         nxt(); dec(0,0, 0,0, 0,0, 0,1, 0,0); pc_freeze = 1;
         push($sformatf("str_t%0d", i),
              (i >= 1 && i <= 3) ? 6'b001000 : 6'b000000);
      end
      // flush does not drop the busy window
      nxt(); dec(0,0, 0,0, 0,0, 0,1, 0,0); push("st2", 6'b000000);
      nxt(); do_flush = 1; push("st2_fl", 6'b000000);
      nxt(); dec(0,0, 0,0, 0,0, 0,1, 0,0); pc_freeze = 1;
      push("st2_busy", 6'b001000);
      idle_n(4);

      // mispredicted branch
      nxt(); dec(0,0, 0,0, 0,0, 0,0, 1,1); push("br_t0", 6'b000100);
      nxt(); push("br_t1", 6'b000100);
      nxt(); ex_br_taken = 0; push("br_t2", 6'b000110);
      nxt(); push("br_t3", 6'b000000);
      // correct prediction
      nxt(); dec(0,0, 0,0, 0,0, 0,0, 1,0); push("brc_t0", 6'b000100);
      nxt(); push("brc_t1", 6'b000100);
      nxt(); push("brc_t2", 6'b000111);
      nxt(); push("brc_t3", 6'b000000);
      // capture in the resolution cycle
      nxt(); dec(0,0, 0,0, 0,0, 0,0, 1,1); push("bb_t0", 6'b000100);
      nxt(); push("bb_t1", 6'b000100);
      nxt(); dec(0,0, 0,0, 0,0, 0,0, 1,0); ex_br_taken = 1;
      push("bb_t2", 6'b000111);
      nxt(); push("bb_t3", 6'b000100);
      nxt(); ex_br_taken = 1; push("bb_t4", 6'b000110);
      nxt(); push("bb_t5", 6'b000000);
      // frozen or flushed branch is not captured
      nxt(); dec(0,0, 0,0, 0,0, 0,0, 1,1); pc_freeze = 1;
      push("brfz", 6'b000100);
      nxt(); push("brfz_n", 6'b000000);
      nxt(); dec(0,0, 0,0, 0,0, 0,0, 1,1); do_flush = 1;
      push("brfl", 6'b000100);
      nxt(); push("brfl_n", 6'b000000);
      // reset mid-branch
      nxt(); dec(0,0, 0,0, 0,0, 0,0, 1,1); push("brr_t0", 6'b000100);
      nxt(); rst = 1; push("brr_t1", 6'b000100);
      idle_n(4);

      // random traffic checked against the model
      for (int i = 0; i < 400; i++) begin
         logic mem, br;
         nxt();
         rst = ($urandom_range(0, 60) == 0);
         if ($urandom_range(0, 3) != 0) begin
            br  = ($urandom_range(0, 4) == 0);
            mem = !br && ($urandom_range(0, 2) == 0);
            dec(5'($urandom_range(0, 3)), 1'($urandom),
                5'($urandom_range(0, 3)), 1'($urandom),
                5'($urandom_range(0, 3)), 1'($urandom),
                mem && 1'($urandom), mem, br, 1'($urandom));
         end
         ex_br_taken = 1'($urandom);
         pc_freeze = ($urandom_range(0, 4) == 0);
         do_flush = ($urandom_range(0, 7) == 0);
         push("rand", model_out());
      end

      repeat (3) @(negedge clk);
      if (sb_q.size() != 0)
         chk("drain", 6'(sb_q.size()), 6'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
